weighted_rr_arbiter: RTL

- Parametrised successor to the single-cycle fixed-priority arbiter.
- N requesters; same-cycle combinational grant, like its predecessor.
- Adds a runtime-selectable mode: fixed priority or weighted round-robin.
- In weighted round-robin, each requester may hold the grant for a programmable number of extra consecutive cycles. Used wherever shared resources need fairness with bandwidth shaping.

---
 rtl/arb_pkg.sv | 22 ++
 rtl/rr_priority_picker.sv | 27 ++
 rtl/weighted_rr_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_WRR   = 1'b1
  } arb_mode_e;

  // Upper bound on requester count supported by onehot_to_idx.
  localparam int unsigned MaxReq = 1024;

  // OR-reduction of the indices of set bits; exact for one-hot or zero input.
  function automatic int unsigned onehot_to_idx(input logic [MaxReq-1:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      if (onehot[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Find-first-set over req_i starting at ptr_i, wrapping past N-1 back to 0.
module rr_priority_picker import arb_pkg::*; #(
  parameter int unsigned N  = 16,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [N-1:0] upper_mask;
  logic [N-1:0] upper_req;
  logic [N-1:0] src;

  // Prefer requests at or above ptr; otherwise wrap to the lowest request overall.
  always_comb begin
    upper_mask = ~((N'(1) << ptr_i) - N'(1));
    upper_req  = req_i & upper_mask;
    src        = (|upper_req) ? upper_req : req_i;
    gnt_o      = src & (~src + N'(1));
    idx_o      = IW'(onehot_to_idx(MaxReq'(gnt_o)));
    valid_o    = |req_i;
  end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// N-way arbiter with runtime choice of fixed priority or weighted round-robin.
// Grant is combinational; the owner may hold the grant for weight+1 cycles.
module weighted_rr_arbiter import arb_pkg::*; #(
  parameter int unsigned N  = 16,
  parameter int unsigned W  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req_i,
  input  logic            mode_i,
  input  logic [N*W-1:0]  weight_i,
  output logic [N-1:0]    gnt_o,
  output logic            gnt_valid_o,
  output logic [IW-1:0]   gnt_idx_o
);

  arb_mode_e     mode;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic          owner_v_q, owner_v_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]  owner_weight;
  logic          hold;

  logic [IW-1:0] pick_ptr;
  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;

  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_valid;

  assign mode         = arb_mode_e'(mode_i);
  // Live weight, so a reprogrammed weight affects an ongoing hold immediately.
  assign owner_weight = weight_i[owner_q*W +: W];
  assign hold         = (mode == ARB_WRR) && owner_v_q && req_i[owner_q] &&
                        (cnt_q < owner_weight);
  // Fixed priority is just a search anchored at bit 0.
  assign pick_ptr     = (mode == ARB_WRR) ? ptr_q : '0;

  rr_priority_picker #(
    .N  (N),
    .IW (IW)
  ) u_picker (
    .req_i   (req_i),
    .ptr_i   (pick_ptr),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Select between holding the current owner and the pointer search.
  always_comb begin
    gnt       = pick_gnt;
    gnt_idx   = pick_idx;
    gnt_valid = pick_valid;
    if (hold) begin
      gnt       = N'(1) << owner_q;
      gnt_idx   = owner_q;
      gnt_valid = 1'b1;
    end
  end

  // Outputs are forced idle while reset is held.
  always_comb begin
    gnt_o       = reset ? '0   : gnt;
    gnt_valid_o = reset ? 1'b0 : gnt_valid;
    gnt_idx_o   = reset ? '0   : gnt_idx;
  end

  // Next-state: pointer advances past each grant; cnt tracks the owner's streak.
  always_comb begin
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    owner_v_d = owner_v_q;
    cnt_d     = cnt_q;
    if (mode == ARB_FIXED || !gnt_valid) begin
      owner_v_d = 1'b0;
      cnt_d     = '0;
    end else begin
      ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      if (owner_v_q && (gnt_idx == owner_q)) begin
        // Saturate so an over-long streak never wraps back into the hold window.
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      end else begin
        owner_d   = gnt_idx;
        owner_v_d = 1'b1;
        cnt_d     = '0;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q     <= '0;
      owner_q   <= '0;
      owner_v_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      owner_v_q <= owner_v_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
